// File: rtl/and8bit_serial_pkg.sv
// Shared definitions for the bit-serial logic lane: state encoding, lane op codes,
// default width and the per-bit lane function.
// Optional build macro: AND8BIT_SERIAL_OPSEL_EN (selects AND/OR/XOR/NAND per operation).
package and8bit_serial_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_NAND = 2'b11;

   // One-gate-wide lane: the function applied to a single operand bit pair.
   function automatic logic lane_op(input logic a, input logic b, input logic [1:0] op);
      logic r;
      unique case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NAND: r = ~(a & b);
         default: r = a & b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/and8bit_serial_if.sv
// Operand/result bundle of the bit-serial lane.
// Optional build macro: AND8BIT_SERIAL_OPSEL_EN adds the 2-bit op select.
interface and8bit_serial_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] inA;
   logic [WIDTH-1:0] inB;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             done;
   logic             bitOut;
`ifdef AND8BIT_SERIAL_OPSEL_EN
   logic [1:0]       op;

   modport master (output start, inA, inB, op, input out, busy, done, bitOut);
   modport slave  (input start, inA, inB, op, output out, busy, done, bitOut);
`else
   modport master (output start, inA, inB, input out, busy, done, bitOut);
   modport slave  (input start, inA, inB, output out, busy, done, bitOut);
`endif
endinterface

// File: rtl/and8bit_serial_shift_reg_n.sv
// WIDTH-bit right shift register with parallel load and shift enable.
// Load has priority; the serial input enters at the MSB.
module shift_reg_n #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_shift,
   input  logic             i_sin,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Load on accept, otherwise shift right one place when enabled.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_load_val;
      end else if (i_shift) begin
         r_q <= {i_sin, r_q[WIDTH-1:1]};
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/and8bit_serial.sv
// Bit-serial logic lane: captures two operands on start, produces one result bit per
// clock LSB first, then presents the reassembled word with a one-cycle done pulse.
// Optional build macro: AND8BIT_SERIAL_OPSEL_EN (per-operation AND/OR/XOR/NAND select).
module and8bit_serial
   import and8bit_serial_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input logic                clk,
   input logic                rstN,
   and8bit_serial_if.slave    bus
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   state_t           r_state;
   state_t           w_state_next;
   logic [CntW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] w_sh_a;
   logic [WIDTH-1:0] w_sh_b;
   logic [WIDTH-1:0] w_res;
   logic [1:0]       w_op;
   logic             w_accept;
   logic             w_shift;
   logic             w_last;
   logic             w_bit;

   assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
   assign w_shift  = (r_state == SHIFT);
   assign w_last   = w_shift && (r_cnt == CntW'(WIDTH - 1));
   assign w_bit    = w_shift ? lane_op(w_sh_a[0], w_sh_b[0], w_op) : 1'b0;

`ifdef AND8BIT_SERIAL_OPSEL_EN
   logic [1:0] r_op;

   // Op is captured with the operands so mid-operation changes are ignored.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_op <= OP_AND;
      end else if (w_accept) begin
         r_op <= bus.op;
      end
   end

   assign w_op = r_op;
`else
   assign w_op = OP_AND;
`endif

   shift_reg_n #(.WIDTH(WIDTH)) u_sh_a (
      .clk        (clk),
      .rstN       (rstN),
      .i_load     (w_accept),
      .i_load_val (bus.inA),
      .i_shift    (w_shift),
      .i_sin      (1'b0),
      .o_q        (w_sh_a)
   );

   shift_reg_n #(.WIDTH(WIDTH)) u_sh_b (
      .clk        (clk),
      .rstN       (rstN),
      .i_load     (w_accept),
      .i_load_val (bus.inB),
      .i_shift    (w_shift),
      .i_sin      (1'b0),
      .o_q        (w_sh_b)
   );

   // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
   shift_reg_n #(.WIDTH(WIDTH)) u_res (
      .clk        (clk),
      .rstN       (rstN),
      .i_load     (w_accept),
      .i_load_val ({WIDTH{1'b0}}),
      .i_shift    (w_shift),
      .i_sin      (w_bit),
      .o_q        (w_res)
   );

   // State register.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; start is only honoured in IDLE or DONE.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (bus.start) w_state_next = SHIFT;
         SHIFT:   if (w_last) w_state_next = DONE;
         DONE:    w_state_next = bus.start ? SHIFT : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Bit counter: cleared on accept, advanced once per processed bit.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= '0;
      end else if (w_shift) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Output word loads the final shifted value on the edge entering DONE only,
   // so the partial result is never visible.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_out <= '0;
      end else if (w_last) begin
         r_out <= {w_bit, w_res[WIDTH-1:1]};
      end
   end

   assign bus.out    = r_out;
   assign bus.busy   = w_shift;
   assign bus.done   = (r_state == DONE);
   assign bus.bitOut = w_bit;

endmodule

// File: tb/tb_and8bit_serial.sv
// Self-checking bench for and8bit_serial: directed edge cases plus randomized operands,
// compared against a word-level reference of the lane function.
// Optional build macro: AND8BIT_SERIAL_OPSEL_EN (exercises the op select).
module tb_and8bit_serial;

   localparam int unsigned W = 8;

   logic       clk  = 1'b0;
   logic       rstN = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] last_res = 8'h00;

   and8bit_serial_if #(.WIDTH(W)) bus_if ();

   and8bit_serial #(.WIDTH(W)) dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Whole-word reference of the lane function.
   function automatic logic [7:0] ref_word(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op);
      case (op)
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         2'b11:   return ~(a & b);
         default: return a & b;
      endcase
   endfunction

   task automatic set_op(input logic [1:0] op);
`ifdef AND8BIT_SERIAL_OPSEL_EN
      bus_if.op = op;
`else
      if (op != 2'b00) $display("note: op select not built, op ignored");
`endif
   endtask

   // One full operation with start pulsed for a single cycle; operands and op are
   // scrambled right after the accept edge to show they are not resampled.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input string tag);
      logic [7:0] exp;
      exp = ref_word(a, b, op);
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.inA   = a;
      bus_if.inB   = b;
      set_op(op);
      for (int i = 0; i < int'(W); i++) begin
         @(negedge clk);
         if (i == 0) begin
            bus_if.start = 1'b0;
            bus_if.inA   = 8'($urandom);
            bus_if.inB   = 8'($urandom);
`ifdef AND8BIT_SERIAL_OPSEL_EN
            set_op(2'($urandom));
`endif
         end
         check_eq($sformatf("%s busy[%0d]", tag, i), 32'(bus_if.busy), 32'd1);
         check_eq($sformatf("%s bitOut[%0d]", tag, i), 32'(bus_if.bitOut), 32'(exp[i]));
         check_eq($sformatf("%s done_low[%0d]", tag, i), 32'(bus_if.done), 32'd0);
         check_eq($sformatf("%s out_hold[%0d]", tag, i), 32'(bus_if.out), 32'(last_res));
      end
      @(negedge clk);
      check_eq($sformatf("%s done", tag), 32'(bus_if.done), 32'd1);
      check_eq($sformatf("%s busy_low", tag), 32'(bus_if.busy), 32'd0);
      check_eq($sformatf("%s out", tag), 32'(bus_if.out), 32'(exp));
      last_res = exp;
   endtask

   initial begin
      logic [7:0] ea [5];
      logic [7:0] eb [5];
      int         n_done;
      logic [7:0] got_out;

      bus_if.start = 1'b0;
      bus_if.inA   = 8'h00;
      bus_if.inB   = 8'h00;
      set_op(2'b00);

      // Reset state.
      #12;
      check_eq("rst out", 32'(bus_if.out), 32'd0);
      check_eq("rst busy", 32'(bus_if.busy), 32'd0);
      check_eq("rst done", 32'(bus_if.done), 32'd0);
      check_eq("rst bitOut", 32'(bus_if.bitOut), 32'd0);
      @(negedge clk);
      rstN = 1'b1;

      // Basic AND with bit sequence.
      run_op(8'hC3, 8'hF0, 2'b00, "basic");

      // Edge values.
      ea = '{8'h00, 8'hFF, 8'hAA, 8'h34, 8'h00};
      eb = '{8'hFF, 8'hFF, 8'h55, 8'h76, 8'h00};
      for (int i = 0; i < 5; i++) run_op(ea[i], eb[i], 2'b00, $sformatf("edge%0d", i));

`ifdef AND8BIT_SERIAL_OPSEL_EN
      run_op(8'hAA, 8'h55, 2'b01, "op_or");
      run_op(8'hAA, 8'h55, 2'b10, "op_xor");
      run_op(8'hAA, 8'h55, 2'b11, "op_nand");
      run_op(8'hAA, 8'h55, 2'b00, "op_and");
`endif

      // Randomized operands (and op when built).
      for (int i = 0; i < 20; i++) begin
`ifdef AND8BIT_SERIAL_OPSEL_EN
         run_op(8'($urandom), 8'($urandom), 2'($urandom), $sformatf("rand%0d", i));
`else
         run_op(8'($urandom), 8'($urandom), 2'b00, $sformatf("rand%0d", i));
`endif
      end

      // start while busy is ignored.
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.inA   = 8'h34;
      bus_if.inB   = 8'h76;
      set_op(2'b00);
      n_done  = 0;
      got_out = 8'h00;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (bus_if.done === 1'b1) begin
            n_done++;
            got_out = bus_if.out;
         end
         if (k == 1) bus_if.start = 1'b0;
         if (k == 2) begin
            bus_if.start = 1'b1;
            bus_if.inA   = 8'hFF;
            bus_if.inB   = 8'hFF;
         end
         if (k == 3) bus_if.start = 1'b0;
      end
      check_eq("busy_ign done_count", 32'(n_done), 32'd1);
      check_eq("busy_ign out", 32'(got_out), 32'h34);
      last_res = 8'h34;

      run_op(8'h0F, 8'h3C, 2'b00, "pre_b2b");

      // Back-to-back with start held high.
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.inA   = 8'h34;
      bus_if.inB   = 8'h76;
      for (int k = 1; k <= 22; k++) begin
         logic [7:0] exp_out;
         @(negedge clk);
         exp_out = (k < 9) ? last_res : ((k < 18) ? 8'h34 : 8'hFF);
         check_eq($sformatf("b2b done[%0d]", k), 32'(bus_if.done),
                  32'((k == 9) || (k == 18)));
         check_eq($sformatf("b2b out[%0d]", k), 32'(bus_if.out), 32'(exp_out));
         if (k == 10) check_eq("b2b busy_after_done", 32'(bus_if.busy), 32'd1);
         if (k == 1) begin
            bus_if.inA = 8'hFF;
            bus_if.inB = 8'hFF;
         end
         if (k == 10) bus_if.start = 1'b0;
      end
      last_res = 8'hFF;

      // Mid-operation asynchronous reset.
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.inA   = 8'hAA;
      bus_if.inB   = 8'hFF;
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rstN = 1'b0;
      #1;
      check_eq("midrst out", 32'(bus_if.out), 32'd0);
      check_eq("midrst busy", 32'(bus_if.busy), 32'd0);
      check_eq("midrst done", 32'(bus_if.done), 32'd0);
      check_eq("midrst bitOut", 32'(bus_if.bitOut), 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      last_res = 8'h00;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check_eq($sformatf("postrst done[%0d]", k), 32'(bus_if.done), 32'd0);
         check_eq($sformatf("postrst busy[%0d]", k), 32'(bus_if.busy), 32'd0);
      end
      run_op(8'h34, 8'h76, 2'b00, "fresh");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/and8bit_serial.md
Name: and8bit_serial

Overview:
- Bit-serial counterpart of the parallel 8-bit AND: captures two 8-bit operands on a start strobe and computes one result bit per clock, LSB first.
- Result is reassembled into an 8-bit parallel word and flagged with a one-cycle done pulse.
- Sits in the NAND-built datapath wherever a one-gate-wide logic lane replaces eight parallel gates and latency is acceptable.
- Gate-level lane is a single 2-input AND per cycle; a shift/count controller sequences it.

Parameters:
WIDTH, 8, operand/result width in bits; the count register is clog2(WIDTH)+1 bits.

Ports:
clk  input  1  clock; all state changes on the rising edge
rstN  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
inA  input  WIDTH  operand A; sampled on the accepting edge only
inB  input  WIDTH  operand B; sampled on the accepting edge only
out  output  WIDTH  result word; valid while done=1, then held until the next accept
busy  output  1  high in SHIFT state
done  output  1  one-cycle pulse: result complete
bitOut  output  1  current serial result bit; valid while busy=1

Behaviour:
- Reset (rstN=0, asynchronous, any state or cycle): state=IDLE; out=0, busy=0, done=0, bitOut=0; shift registers and count cleared.
- Mid-operation reset aborts the operation. No done pulse is produced. The first start after release is a fresh operation.
- States:
  - IDLE, start=1 -> SHIFT.
  - SHIFT, count=WIDTH-1 -> DONE.
  - DONE -> SHIFT if start=1, else IDLE.
- Accept (edge E, state IDLE or DONE with start=1):
  - Load shA<=inA, shB<=inB.
  - Clear count and the result shift register.
  - State becomes SHIFT.
- SHIFT:
  - bitOut = shA[0] & shB[0].
  - Each edge: result shift register <= {bitOut, res[WIDTH-1:1]}; shA, shB shift right one; count+1.
- Latency:
  - Accept at edge E. Bits are processed on edges E+1..E+WIDTH.
  - State=DONE and done=1 in the cycle after edge E+WIDTH. out = full result in that same cycle.
  - Accept-to-done is WIDTH+1 edges (9 for WIDTH=8).
- out is driven from a dedicated register. It updates only on the edge entering DONE and is stable otherwise; the partial result is never visible on out.
- start while busy=1: ignored; no queuing; inA/inB changes have no effect.
- start in DONE: back-to-back accept. done is high for exactly that one cycle. busy rises the next cycle. out holds the previous result until the new DONE.
- start held continuously: a new operation every WIDTH+1 cycles.
- X/Z on inA/inB outside the accept edge must not propagate.

Optional Feature:
- Macro: AND8BIT_SERIAL_OPSEL_EN.
- Defined:
  - Adds input op [1:0], sampled with the operands on accept.
  - Encoding: 00 AND, 01 OR, 10 XOR, 11 NAND; applied per bit in the serial lane.
  - Changes to op while busy are ignored.
- Undefined:
  - No op port; lane is AND only.
  - Timing identical in both builds.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Op encodings for AND8BIT_SERIAL_OPSEL_EN.
  - Default WIDTH constant.
- One natural sub-module: shift_reg_n, a WIDTH-bit right shift register with load and shift-enable, instantiated for A, B and the result.
- Controller FSM and counter stay in the top.

Test Plan:
- Reset: rstN=0 mid-SHIFT -> out=00, busy=0, done=0 immediately without a clock edge; no done pulse after release.
- Basic AND: inA=C3, inB=F0, start pulse -> busy for 8 cycles; bitOut sequence LSB-first 0,0,0,0,0,0,1,1; done on the 9th edge after accept; out=C0.
- Edge values: 00&FF -> 00; FF&FF -> FF; AA&55 -> 00; 34&76 -> 34. Check each against the parallel AND of the same operands.
- Ignore while busy: accept 34&76; at cycle 3 assert start with inA=FF, inB=FF -> result still 34, exactly one done pulse.
- Back-to-back: start held high across operands 34&76 then FF&FF -> done pulses 9 cycles apart, out=34 then FF; out stable between pulses.
- With AND8BIT_SERIAL_OPSEL_EN: inA=AA, inB=55 with op=01 -> FF; op=10 -> FF; op=11 -> FF; op=00 -> 00.
